// File: rtl/imem_loadable.sv
// ---------------------------------------------------------------------------
// imem_loadable
//
// Writable instruction memory that sits between the fetch/PC logic and the
// decoder. It holds DEPTH words of INSTR_W bits. The word at PC comes back
// with one cycle of registered latency. A valid/ready loader port replaces
// the contents at runtime.
//
// After reset the block spends DEPTH cycles writing zero (the "done"
// encoding) into every word. It then serves fetches. A load overwrites words
// from address 0 upward and leaves every word past the last one written
// unchanged.
//
// Parameters
//   INSTR_W  instruction width in bits
//   PC_W     program counter width
//   DEPTH    number of instruction words, legal range 2 .. 2**PC_W
//
// Ports
//   Clk         in   rising-edge clock
//   Reset_n     in   asynchronous active-low reset
//   PC          in   fetch address
//   iptr        out  registered instruction for the PC sampled on the previous edge
//   inst_valid  out  iptr holds a legal fetched word
//   oob         out  the previous PC was >= DEPTH
//   ld_start    in   pulse that requests a program load
//   ld_valid    in   ld_data carries a word
//   ld_data     in   instruction word to write
//   ld_last     in   marks the final word of a load
//   ld_ready    out  a loader word is accepted this cycle
//   ld_done     out  one-cycle pulse when a load completes
//   ld_count    out  number of words written by the last completed load
// ---------------------------------------------------------------------------
module imem_loadable #(
    parameter int INSTR_W = 9,
    parameter int PC_W    = 8,
    parameter int DEPTH   = 256
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [PC_W-1:0]    PC,
    output logic [INSTR_W-1:0] iptr,
    output logic               inst_valid,
    output logic               oob,
    input  logic               ld_start,
    input  logic               ld_valid,
    input  logic [INSTR_W-1:0] ld_data,
    input  logic               ld_last,
    output logic               ld_ready,
    output logic               ld_done,
    output logic [PC_W:0]      ld_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PC_W:0] DEPTH_C = (PC_W + 1)'(DEPTH);
    localparam logic [PC_W:0] LAST_C  = (PC_W + 1)'(DEPTH - 1);
    localparam logic [PC_W:0] ONE_C   = (PC_W + 1)'(1);

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;

    logic [INSTR_W-1:0] mem [DEPTH];

    logic [1:0]         state_q,      state_d;
    // Shared pointer: it counts clear addresses in CLEAR and write
    // addresses in LOAD. It is one bit wider than PC so that the number of
    // accepted words (up to DEPTH) can be formed as ptr_q + 1 without wrapping.
    logic [PC_W:0]      ptr_q,        ptr_d;
    logic [INSTR_W-1:0] iptr_q,       iptr_d;
    logic               inst_valid_q, inst_valid_d;
    logic               oob_q,        oob_d;
    logic               ld_done_q,    ld_done_d;
    logic [PC_W:0]      ld_count_q,   ld_count_d;

    logic               mem_we;
    logic [AW-1:0]      mem_waddr;
    logic [INSTR_W-1:0] mem_wdata;
    logic               pc_in_range;
    logic [INSTR_W-1:0] rd_word;

    assign pc_in_range = ({1'b0, PC} < DEPTH_C);
    assign mem_waddr   = ptr_q[AW-1:0];

    // An out-of-range PC must never index the array, so the read is gated here.
    always_comb begin
        rd_word = '0;
        if (pc_in_range) begin
            rd_word = mem[PC[AW-1:0]];
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        iptr_d       = '0;
        inst_valid_d = 1'b0;
        oob_d        = 1'b0;
        ld_done_d    = 1'b0;
        ld_count_d   = ld_count_q;
        mem_we       = 1'b0;
        mem_wdata    = '0;

        case (state_q)
            ST_CLEAR: begin
                // Zero one word per cycle. The loader inputs are ignored here.
                mem_we = 1'b1;
                if (ptr_q == LAST_C) begin
                    state_d = ST_RUN;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ONE_C;
                end
            end

            ST_RUN: begin
                // The fetch on the same edge as ld_start still completes.
                inst_valid_d = 1'b1;
                iptr_d       = rd_word;
                oob_d        = ~pc_in_range;
                if (ld_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                end
            end

            ST_LOAD: begin
                // ld_start is ignored here, so a second pulse does not restart the load.
                if (ld_valid) begin
                    mem_we    = 1'b1;
                    mem_wdata = ld_data;
                    if (ld_last || (ptr_q == LAST_C)) begin
                        // When the last address is filled without ld_last, the
                        // load ends there and any further words are dropped.
                        state_d    = ST_RUN;
                        ptr_d      = '0;
                        ld_count_d = ptr_q + ONE_C;
                        ld_done_d  = 1'b1;
                    end else begin
                        ptr_d = ptr_q + ONE_C;
                    end
                end
            end

            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_CLEAR;
            ptr_q        <= '0;
            iptr_q       <= '0;
            inst_valid_q <= 1'b0;
            oob_q        <= 1'b0;
            ld_done_q    <= 1'b0;
            ld_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            iptr_q       <= iptr_d;
            inst_valid_q <= inst_valid_d;
            oob_q        <= oob_d;
            ld_done_q    <= ld_done_d;
            ld_count_q   <= ld_count_d;
        end
    end

    // The array has no reset, so it can map onto a simple dual-port RAM.
    // The CLEAR sweep provides the initial contents.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign iptr       = iptr_q;
    assign inst_valid = inst_valid_q;
    assign oob        = oob_q;
    assign ld_ready   = (state_q == ST_LOAD);
    assign ld_done    = ld_done_q;
    assign ld_count   = ld_count_q;

endmodule

// File: tb/tb_imem_loadable.sv
module tb_imem_loadable;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;

    // DUT A: default DEPTH=256
    logic [7:0] a_pc = '0;
    logic [8:0] a_iptr;
    logic       a_inst_valid, a_oob, a_ld_ready, a_ld_done;
    logic       a_ld_start = 1'b0, a_ld_valid = 1'b0, a_ld_last = 1'b0;
    logic [8:0] a_ld_data = '0;
    logic [8:0] a_ld_count;

    // DUT B: DEPTH=16, PC_W=8
    logic [7:0] b_pc = '0;
    logic [8:0] b_iptr;
    logic       b_inst_valid, b_oob, b_ld_ready, b_ld_done;
    logic       b_ld_start = 1'b0, b_ld_valid = 1'b0, b_ld_last = 1'b0;
    logic [8:0] b_ld_data = '0;
    logic [8:0] b_ld_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    imem_loadable #(.INSTR_W(9), .PC_W(8), .DEPTH(256)) u_a (
        .Clk(Clk), .Reset_n(Reset_n), .PC(a_pc), .iptr(a_iptr),
        .inst_valid(a_inst_valid), .oob(a_oob), .ld_start(a_ld_start),
        .ld_valid(a_ld_valid), .ld_data(a_ld_data), .ld_last(a_ld_last),
        .ld_ready(a_ld_ready), .ld_done(a_ld_done), .ld_count(a_ld_count)
    );

    imem_loadable #(.INSTR_W(9), .PC_W(8), .DEPTH(16)) u_b (
        .Clk(Clk), .Reset_n(Reset_n), .PC(b_pc), .iptr(b_iptr),
        .inst_valid(b_inst_valid), .oob(b_oob), .ld_start(b_ld_start),
        .ld_valid(b_ld_valid), .ld_data(b_ld_data), .ld_last(b_ld_last),
        .ld_ready(b_ld_ready), .ld_done(b_ld_done), .ld_count(b_ld_count)
    );

    typedef struct {
        logic       sel;       // 0 = DUT A, 1 = DUT B
        logic [7:0] pc;
        logic [8:0] exp_iptr;
        logic       exp_oob;
    } rd_vec_t;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Load nwords words (value = index+1) into DUT A. The valid pattern comes
    // from vpat (LSB first); once the pattern runs out, valid stays high.
    task automatic a_load(input int nwords, input logic use_last,
                          input logic [7:0] vpat, input int vlen,
                          output int acc, output int dones);
        int  cyc;
        logic v, rdy;
        acc = 0; dones = 0; cyc = 0;
        a_ld_start = 1'b1;
        tick();
        a_ld_start = 1'b0;
        chk("start_edge_fetch_valid", 32'(a_inst_valid), 32'd1);
        chk("load_ready_high", 32'(a_ld_ready), 32'd1);
        while (acc < nwords && cyc < 64) begin
            v = (cyc < vlen) ? vpat[cyc] : 1'b1;
            rdy = a_ld_ready;
            a_ld_valid = v;
            a_ld_data  = v ? 9'(acc + 1) : 9'h1FF;
            a_ld_last  = use_last && v && (acc == nwords - 1);
            tick();
            if (v && rdy) acc++;
            if (a_ld_done) dones++;
            cyc++;
        end
        a_ld_valid = 1'b0;
        a_ld_last  = 1'b0;
        chk("load_end_inst_valid_low", 32'(a_inst_valid), 32'd0);
        tick();
        chk("first_run_inst_valid", 32'(a_inst_valid), 32'd1);
        if (a_ld_done) dones++;
        tick();
        if (a_ld_done) dones++;
        chk("ready_low_after_load", 32'(a_ld_ready), 32'd0);
    endtask

    rd_vec_t vecs [12];

    initial begin
        int zeros, first_one, acc, dones, rdy_cnt;

        vecs[0]  = '{1'b0, 8'd0,   9'h001, 1'b0};
        vecs[1]  = '{1'b0, 8'd1,   9'h002, 1'b0};
        vecs[2]  = '{1'b0, 8'd2,   9'h003, 1'b0};
        vecs[3]  = '{1'b0, 8'd3,   9'h000, 1'b0};
        vecs[4]  = '{1'b0, 8'd5,   9'h000, 1'b0};
        vecs[5]  = '{1'b0, 8'd255, 9'h000, 1'b0};
        vecs[6]  = '{1'b1, 8'd20,  9'h000, 1'b1};
        vecs[7]  = '{1'b1, 8'd15,  9'h010, 1'b0};
        vecs[8]  = '{1'b1, 8'd0,   9'h001, 1'b0};
        vecs[9]  = '{1'b1, 8'd16,  9'h000, 1'b1};
        vecs[10] = '{1'b1, 8'd255, 9'h000, 1'b1};
        vecs[11] = '{1'b1, 8'd7,   9'h008, 1'b0};

        // ---- reset state
        tick(); tick();
        chk("rst_iptr",       32'(a_iptr),       32'd0);
        chk("rst_inst_valid", 32'(a_inst_valid), 32'd0);
        chk("rst_oob",        32'(a_oob),        32'd0);
        chk("rst_ld_ready",   32'(a_ld_ready),   32'd0);
        chk("rst_ld_done",    32'(a_ld_done),    32'd0);
        chk("rst_ld_count",   32'(a_ld_count),   32'd0);

        // ---- CLEAR length with PC=5
        a_pc = 8'd5;
        zeros = 0; first_one = 0;
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (first_one == 0) begin
                if (a_inst_valid) first_one = c;
                else zeros++;
            end
        end
        chk("clear_zero_cycles", 32'(zeros), 32'd256);
        chk("clear_first_valid", 32'(first_one), 32'd257);
        chk("run_iptr",       32'(a_iptr),       32'd0);
        chk("run_inst_valid", 32'(a_inst_valid), 32'd1);
        chk("run_oob",        32'(a_oob),        32'd0);

        // ---- DUT B: 20 words, no ld_last, truncated at 16
        b_ld_start = 1'b1;
        tick();
        b_ld_start = 1'b0;
        acc = 0; dones = 0;
        for (int i = 0; i < 20; i++) begin
            rdy_cnt = int'(b_ld_ready);
            b_ld_valid = 1'b1;
            b_ld_data  = 9'(i + 1);
            tick();
            if (rdy_cnt != 0) acc++;
            if (b_ld_done) dones++;
        end
        b_ld_valid = 1'b0;
        tick();
        if (b_ld_done) dones++;
        chk("b_trunc_accepts", 32'(acc),        32'd16);
        chk("b_trunc_done",    32'(dones),      32'd1);
        chk("b_trunc_count",   32'(b_ld_count), 32'd16);
        chk("b_ready_low",     32'(b_ld_ready), 32'd0);

        // ---- DUT A: 3-word load with ld_last
        a_load(3, 1'b1, 8'hFF, 0, acc, dones);
        chk("a_load1_accepts", 32'(acc),        32'd3);
        chk("a_load1_done",    32'(dones),      32'd1);
        chk("a_load1_count",   32'(a_ld_count), 32'd3);

        // ---- repeat with ld_valid pattern 1,0,0,1,0,1
        a_load(3, 1'b1, 8'b0010_1001, 6, acc, dones);
        chk("a_load2_accepts", 32'(acc),        32'd3);
        chk("a_load2_done",    32'(dones),      32'd1);
        chk("a_load2_count",   32'(a_ld_count), 32'd3);

        // ---- read table
        for (int k = 0; k < 12; k++) begin
            if (vecs[k].sel) b_pc = vecs[k].pc;
            else             a_pc = vecs[k].pc;
            tick();
            if (vecs[k].sel) begin
                chk($sformatf("rd_b_iptr[%0d]", k), 32'(b_iptr),       32'(vecs[k].exp_iptr));
                chk($sformatf("rd_b_oob[%0d]", k),  32'(b_oob),        32'(vecs[k].exp_oob));
                chk($sformatf("rd_b_vld[%0d]", k),  32'(b_inst_valid), 32'd1);
            end else begin
                chk($sformatf("rd_a_iptr[%0d]", k), 32'(a_iptr),       32'(vecs[k].exp_iptr));
                chk($sformatf("rd_a_oob[%0d]", k),  32'(a_oob),        32'(vecs[k].exp_oob));
                chk($sformatf("rd_a_vld[%0d]", k),  32'(a_inst_valid), 32'd1);
            end
        end

        // ---- reset after 2 of 5 load words
        a_ld_start = 1'b1;
        tick();
        a_ld_start = 1'b0;
        a_ld_valid = 1'b1; a_ld_data = 9'h1AA;
        tick();
        a_ld_data = 9'h1BB;
        tick();
        a_ld_valid = 1'b0;
        #2;
        Reset_n = 1'b0;
        #1;
        chk("midload_rst_ready",    32'(a_ld_ready),   32'd0);
        chk("midload_rst_valid",    32'(a_inst_valid), 32'd0);
        chk("midload_rst_done",     32'(a_ld_done),    32'd0);
        a_pc = 8'd0;
        @(negedge Clk);
        Reset_n = 1'b1;
        zeros = 0; first_one = 0; dones = 0; rdy_cnt = 0;
        for (int c = 1; c <= 300; c++) begin
            // ld_start / ld_valid during CLEAR must be ignored
            a_ld_start = (c == 10 || c == 11);
            a_ld_valid = (c >= 10 && c < 20);
            a_ld_data  = 9'h155;
            tick();
            if (a_ld_done)  dones++;
            if (a_ld_ready) rdy_cnt++;
            if (first_one == 0) begin
                if (a_inst_valid) first_one = c;
                else zeros++;
            end
        end
        a_ld_start = 1'b0;
        a_ld_valid = 1'b0;
        chk("reclear_zero_cycles", 32'(zeros),   32'd256);
        chk("reclear_no_done",     32'(dones),   32'd0);
        chk("reclear_no_ready",    32'(rdy_cnt), 32'd0);
        chk("reclear_pc0",         32'(a_iptr),  32'd0);
        a_pc = 8'd1;
        tick();
        chk("reclear_pc1",         32'(a_iptr),  32'd0);

        // ---- second ld_start inside LOAD must not restart
        dones = 0;
        a_ld_start = 1'b1;
        tick();
        a_ld_start = 1'b0;
        a_ld_valid = 1'b1; a_ld_data = 9'h0A1;
        tick();
        if (a_ld_done) dones++;
        a_ld_valid = 1'b0; a_ld_start = 1'b1;
        tick();
        if (a_ld_done) dones++;
        a_ld_start = 1'b0;
        a_ld_valid = 1'b1; a_ld_data = 9'h0A2;
        tick();
        if (a_ld_done) dones++;
        a_ld_data = 9'h0A3; a_ld_last = 1'b1;
        tick();
        if (a_ld_done) dones++;
        a_ld_valid = 1'b0; a_ld_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (a_ld_done) dones++;
        end
        chk("restart_done_once", 32'(dones),      32'd1);
        chk("restart_count",     32'(a_ld_count), 32'd3);
        for (int i = 0; i < 3; i++) begin
            a_pc = 8'(i);
            tick();
            chk($sformatf("restart_rd[%0d]", i), 32'(a_iptr), 32'(9'h0A1 + 9'(i)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
Parametrised, writable successor to the fixed combinational instruction ROM. It holds DEPTH instructions of INSTR_W bits and returns the word at PC with one-cycle registered latency. Programs are loaded at runtime through a valid/ready loader port, so new kernels run without resynthesis. The block sits between the fetch/PC logic and the decoder.

Parameters:
INSTR_W, 9, instruction width in bits.
PC_W, 8, program counter width.
DEPTH, 256, number of instruction words; legal range 2..2**PC_W.

Ports:
Clk  in  1  single clock, rising edge.
Reset_n  in  1  asynchronous, active-low reset.
PC  in  PC_W  fetch address.
iptr  out  INSTR_W  registered instruction for the PC sampled on the previous edge.
inst_valid  out  1  iptr is a legal fetched word.
oob  out  1  previous PC was >= DEPTH.
ld_start  in  1  request to begin a program load; pulse.
ld_valid  in  1  ld_data is valid.
ld_data  in  INSTR_W  instruction word to write.
ld_last  in  1  marks the final word of a load.
ld_ready  out  1  block accepts a loader word this cycle.
ld_done  out  1  one-cycle pulse when a load completes.
ld_count  out  PC_W+1  number of words written by the last completed load.

Behaviour:
- Reset (async assert):
  - state=CLEAR; iptr=0, inst_valid=0, oob=0, ld_ready=0, ld_done=0, ld_count=0.
  - Clear pointer=0.
- CLEAR state:
  - Writes 0 (the "done" encoding) to mem[ptr] each cycle, ptr++.
  - After writing DEPTH-1 (DEPTH cycles total), go to RUN.
  - ld_start and ld_valid are ignored; inst_valid=0; iptr=0.
- RUN state:
  - Each edge: iptr<=mem[PC] and inst_valid<=1, so latency is 1 cycle.
  - If PC>=DEPTH: iptr<=0, oob<=1, inst_valid<=1. Otherwise oob<=0.
  - ld_ready=0.
  - On ld_start=1: go to LOAD next cycle with write pointer=0. The fetch on that same edge still completes normally.
- LOAD state:
  - ld_ready=1. inst_valid=0 and iptr=0 from the first LOAD cycle on; the decoder must stall.
  - A word is accepted on ld_valid&ld_ready: mem[wptr]<=ld_data, wptr++.
  - Load ends on acceptance of a word with ld_last=1, or on acceptance of word DEPTH-1 (silent truncation).
  - At load end: ld_count<=words accepted, ld_done pulses for exactly 1 cycle, and the state returns to RUN.
  - Memory is not cleared between loads. Words beyond ld_count keep their old contents.
  - ld_valid=0 cycles insert wait states with no timeout.
  - ld_start while in LOAD is ignored and does not restart the load.
- First RUN cycle after a load: inst_valid rises one edge later, reading the updated contents. No stale-data bypass is needed because no reads occur during LOAD.
- Reset mid-CLEAR or mid-LOAD: immediate return to CLEAR.
  - The whole array is re-zeroed; the partial load is discarded.
  - ld_done does not pulse.
- ld_count width PC_W+1 holds DEPTH exactly; no wrap.
- Only one write port and one read port are used, so the array maps to a simple dual-port RAM.

Test Plan:
- Reset, then hold PC=5 for 300 cycles (DEPTH=256) -> inst_valid=0 for exactly 256 cycles, then iptr=0, inst_valid=1, oob=0.
- Pulse ld_start; send 3 words 9'b000_000_001, 9'b000_000_010, 9'b000_000_011 with ld_last on the third -> ld_ready=1 for 3 accepts, ld_done pulses once, ld_count=3. Then PC=0,1,2 -> iptr=001,002,003, each 1 cycle later.
- Repeat that load with ld_valid toggled 1,0,0,1,0,1 -> same contents and ld_count=3; no write occurs on ld_valid=0 cycles.
- DEPTH=16, PC_W=8: load 20 words, none carrying ld_last -> accepts stop after 16, ld_done pulses, ld_count=16. Then PC=20 -> iptr=0, oob=1.
- Assert Reset_n low after 2 of 5 load words, release -> 256-cycle CLEAR, no ld_done pulse, PC=0 reads 0.
- Pulse ld_start in CLEAR -> ignored, state still reaches RUN. Then pulse ld_start, and pulse it again after 1 word is accepted -> a single load with a single ld_done.
